hilo_ctrl: RTL
==============

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset; sampled on rising edge of clock
- op  in  3  operation: 000 NONE, 001 DIV, 010 MULT, 011 MULTU, 100 MTHI, 101 MTLO, 11x reserved (treated as NONE)
- rs_data  in  32  first operand (dividend, multiplicand, MTHI/MTLO source)
- rt_data  in  32  second operand (divisor, multiplier)
- hi  out  32  HI register contents
- lo  out  32  LO register contents
- stall  out  1  high while a multi-cycle operation is in flight
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  32  registered dividend to the divider
- div_divisor  out  32  registered divisor to the divider
- div_busy  in  1  divider busy flag
- div_q  in  32  divider quotient (signed, truncating)
- div_r  in  32  divider remainder (sign of dividend)
REQ-002 The divider contract SHALL be:
- div_busy rises on the edge after div_start is sampled high.
- div_busy stays high for exactly 32 cycles.
- div_q/div_r are valid while div_busy is low after that.
- div_q/div_r depend combinationally on div_dividend/div_divisor, so both SHALL be held stable until writeback.

Function
REQ-003 The FSM SHALL have states IDLE, MUL1, MUL2, DIV_ISSUE, DIV_WAIT; stall = (state != IDLE), registered-state decode only.
REQ-004 op SHALL be accepted only in IDLE; op in any other state SHALL be ignored with no side effect.
REQ-005 MTHI/MTLO accepted in IDLE SHALL write rs_data to hi/lo at that edge (E0), state stays IDLE, stall stays 0.
REQ-006 MULT/MULTU at E0 SHALL latch rs_data/rt_data and go to MUL1.
REQ-007 At E1 the block SHALL register the 64-bit product (signed for MULT, unsigned for MULTU) and go to MUL2.
REQ-008 At E2 the block SHALL write hi = product[63:32] and lo = product[31:0] and go to IDLE; stall is high for exactly 2 cycles.
REQ-009 DIV with rt_data != 0 at E0 SHALL:
- load div_dividend = rs_data and div_divisor = rt_data;
- set div_start = 1 (registered);
- clear seen_busy;
- go to DIV_ISSUE.
REQ-010 In DIV_ISSUE, div_start SHALL be high for exactly that one cycle; at E1 div_start returns to 0 and the state goes to DIV_WAIT.
REQ-011 In DIV_WAIT, seen_busy SHALL set at the first edge where div_busy = 1.
REQ-012 At the first edge with seen_busy = 1 and div_busy = 0, the block SHALL write lo = div_q and hi = div_r and go to IDLE.
REQ-013 With the 32-cycle divider, DIV stall SHALL last exactly 34 cycles (E0 to E34 inclusive of writeback edge).
REQ-014 DIV with rt_data == 0 SHALL NOT pulse div_start; at E0 it SHALL write lo = 32'hFFFF_FFFF and hi = rs_data, state stays IDLE, stall 0.
REQ-015 div_dividend/div_divisor SHALL change only on a DIV accept; they hold their value otherwise.
REQ-016 hi/lo SHALL change only on the write edges defined above; their values are readable every cycle.
REQ-017 If div_busy is already high in DIV_ISSUE, seen_busy SHALL still set only from DIV_WAIT sampling; no early writeback.

Reset
REQ-018 reset high at an edge SHALL force, regardless of state (including mid-MUL or mid-DIV):
- state = IDLE, stall = 0, div_start = 0, seen_busy = 0;
- hi = lo = div_dividend = div_divisor = 0.
REQ-019 op SHALL be ignored at any edge where reset is high.
REQ-020 After reset, a divider result arriving from an aborted DIV SHALL NOT be written, since state is IDLE.

Verification
REQ-021 MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 -> hi = 0x12345678 and lo = 0x9ABCDEF0 one edge after each; stall never high.
REQ-022 MULT rs=0xFFFFFFFE (-2), rt=3 -> stall high 2 cycles; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. MULTU with the same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
REQ-023 DIV rs=-7, rt=2 with a 32-cycle divider model -> div_start 1-cycle pulse; stall 34 cycles; lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
REQ-024 DIV rs=100, rt=0 -> no div_start; same edge lo = 0xFFFFFFFF, hi = 100; stall 0.
REQ-025 DIV rs=50, rt=7, reset asserted 10 cycles into DIV_WAIT -> next edge: state IDLE, hi = lo = 0; later divider completion leaves hi/lo at 0.
REQ-026 MULT issued during DIV_WAIT -> ignored; DIV result written normally; hi/lo never hold a product.

Source files
------------

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: MTHI/MTLO writes, two-cycle multiply pipeline,
// and sequencing of an external 32-cycle divider with writeback into HI/LO.
module hilo_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 2 * DW;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_MUL1      = 3'd1;
  localparam logic [2:0] ST_MUL2      = 3'd2;
  localparam logic [2:0] ST_DIV_ISSUE = 3'd3;
  localparam logic [2:0] ST_DIV_WAIT  = 3'd4;

  localparam logic [2:0] OP_DIV   = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic          r_div_start;
  logic [DW-1:0] r_div_dividend;
  logic [DW-1:0] r_div_divisor;
  logic          r_seen_busy;
  logic [DW-1:0] r_mul_a;
  logic [DW-1:0] r_mul_b;
  logic          r_mul_signed;
  logic [PW-1:0] r_prod;

  logic          w_mthi;
  logic          w_mtlo;
  logic          w_div_zero;
  logic          w_div_accept;
  logic          w_mul_accept;
  logic          w_mul_wb;
  logic          w_div_wb;
  logic          w_seen_set;
  logic [PW-1:0] w_mul_a_ext;
  logic [PW-1:0] w_mul_b_ext;
  logic [PW-1:0] w_prod;

  // Low 64 bits of a 64x64 product equal the 32x32 product for both signednesses
  assign w_mul_a_ext = r_mul_signed ? {{DW{r_mul_a[DW-1]}}, r_mul_a} : {{DW{1'b0}}, r_mul_a};
  assign w_mul_b_ext = r_mul_signed ? {{DW{r_mul_b[DW-1]}}, r_mul_b} : {{DW{1'b0}}, r_mul_b};
  assign w_prod      = w_mul_a_ext * w_mul_b_ext;

  // Next-state and per-edge action decode
  always_comb begin
    w_state_nxt  = r_state;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    w_div_zero   = 1'b0;
    w_div_accept = 1'b0;
    w_mul_accept = 1'b0;
    w_mul_wb     = 1'b0;
    w_div_wb     = 1'b0;
    w_seen_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (op)
          OP_MTHI: w_mthi = 1'b1;
          OP_MTLO: w_mtlo = 1'b1;
          OP_DIV: begin
            if (rt_data == '0) begin
              w_div_zero = 1'b1;
            end else begin
              w_div_accept = 1'b1;
              w_state_nxt  = ST_DIV_ISSUE;
            end
          end
          OP_MULT, OP_MULTU: begin
            w_mul_accept = 1'b1;
            w_state_nxt  = ST_MUL1;
          end
          default: ;
        endcase
      end
      ST_MUL1:      w_state_nxt = ST_MUL2;
      ST_MUL2: begin
        w_mul_wb    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_DIV_ISSUE: w_state_nxt = ST_DIV_WAIT;
      ST_DIV_WAIT: begin
        // Busy must be observed here before a low busy means "done"
        if (!r_seen_busy) begin
          w_seen_set = div_busy;
        end else if (!div_busy) begin
          w_div_wb    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_hi           <= '0;
      r_lo           <= '0;
      r_div_start    <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_seen_busy    <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_mul_signed   <= 1'b0;
      r_prod         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_start <= w_div_accept;
      if (w_div_accept) begin
        r_div_dividend <= rs_data;
        r_div_divisor  <= rt_data;
        r_seen_busy    <= 1'b0;
      end else if (w_seen_set) begin
        r_seen_busy <= 1'b1;
      end
      if (w_mul_accept) begin
        r_mul_a      <= rs_data;
        r_mul_b      <= rt_data;
        r_mul_signed <= (op == OP_MULT);
      end
      if (r_state == ST_MUL1) begin
        r_prod <= w_prod;
      end
      if (w_mthi) begin
        r_hi <= rs_data;
      end else if (w_mtlo) begin
        r_lo <= rs_data;
      end else if (w_div_zero) begin
        r_hi <= rs_data;
        r_lo <= '1;
      end else if (w_mul_wb) begin
        r_hi <= r_prod[PW-1:DW];
        r_lo <= r_prod[DW-1:0];
      end else if (w_div_wb) begin
        r_hi <= div_r;
        r_lo <= div_q;
      end
    end
  end

  assign hi           = r_hi;
  assign lo           = r_lo;
  assign stall        = (r_state != ST_IDLE);
  assign div_start    = r_div_start;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;

endmodule
